// File: rtl/bf_core_v2.sv
// rtl/bf_core_v2.sv - Brainfuck interpreter core with tape cell cache, loop stack and bracket skipper
module bf_core_v2 #(
    parameter int CELL_W      = 8,
    parameter int ADDR_ARRAY  = 9,
    parameter int ADDR_CODE   = 9,
    parameter int STACK_DEPTH = 16
) (
    input  logic                  sysClk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [ADDR_CODE-1:0]  codeAddr,
    input  logic [7:0]            codeIn,
    output logic [ADDR_ARRAY-1:0] arrayAddr,
    output logic [CELL_W-1:0]     arrayDataOut,
    output logic                  arrayWe,
    input  logic [CELL_W-1:0]     arrayDataIn,
    input  logic                  inValid,
    input  logic [7:0]            inData,
    output logic                  inReady,
    output logic                  outValid,
    output logic [7:0]            outData,
    input  logic                  outReady,
    output logic                  done,
    output logic [1:0]            error
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [7:0] OP_INC = 8'h2B, OP_DEC = 8'h2D, OP_RIGHT = 8'h3E, OP_LEFT = 8'h3C;
    localparam logic [7:0] OP_OUT = 8'h2E, OP_IN = 8'h2C, OP_OPEN = 8'h5B, OP_CLOSE = 8'h5D;

    typedef enum logic [2:0] {
        S_LOADCELL, S_FETCH, S_EXEC, S_OUT, S_IN, S_SKIP, S_HALT
    } state_t;

    state_t                state_q;
    logic [ADDR_CODE-1:0]  pc_q, depth_q;
    logic [ADDR_ARRAY-1:0] ptr_q;
    logic [CELL_W-1:0]     cell_q;
    logic [SP_W-1:0]       sp_q;
    logic [1:0]            error_q;
    logic                  load_pend_q, skip_ph_q;
    logic [ADDR_CODE-1:0]  stack_q [STACK_DEPTH];

    logic [ADDR_CODE:0]    pc_inc;
    logic                  pc_wrap, stack_full, push_en;
    logic [SP_W-2:0]       sp_idx, top_idx;
    logic [ADDR_CODE-1:0]  pc_next, top;

    assign pc_inc     = {1'b0, pc_q} + 1'b1;
    assign pc_wrap    = pc_inc[ADDR_CODE];
    assign pc_next    = pc_inc[ADDR_CODE-1:0];
    assign sp_idx     = sp_q[SP_W-2:0];
    assign top_idx    = sp_idx - 1'b1;
    assign top        = stack_q[top_idx];
    assign stack_full = (sp_q == SP_W'(STACK_DEPTH));
    assign push_en    = !reset && state_q == S_EXEC && codeIn == OP_OPEN
                        && cell_q != '0 && !stack_full;

    assign codeAddr  = pc_q;
    assign arrayAddr = ptr_q;
    assign outData   = cell_q[7:0];
    assign error     = error_q;
    assign inReady   = !reset && state_q == S_IN;
    assign outValid  = !reset && state_q == S_OUT;
    assign done      = !reset && state_q == S_HALT;

    // Tape writes happen in the same cycle as the modifying op; cell_q follows them (write-through).
    always_comb begin
        arrayWe      = 1'b0;
        arrayDataOut = cell_q;
        if (!reset) begin
            if (state_q == S_EXEC && (codeIn == OP_INC || codeIn == OP_DEC)) begin
                arrayWe      = 1'b1;
                arrayDataOut = (codeIn == OP_INC) ? cell_q + 1'b1 : cell_q - 1'b1;
            end else if (state_q == S_IN && inValid) begin
                arrayWe      = 1'b1;
                arrayDataOut = CELL_W'(inData);
            end
        end
    end

    always_ff @(posedge sysClk) begin
        if (push_en) stack_q[sp_idx] <= pc_q;
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q     <= S_LOADCELL;
            pc_q        <= '0;
            ptr_q       <= '0;
            sp_q        <= '0;
            depth_q     <= '0;
            cell_q      <= '0;
            error_q     <= 2'b00;
            load_pend_q <= 1'b0;
            skip_ph_q   <= 1'b0;
        end else begin
            if (arrayWe) cell_q <= arrayDataOut;
            case (state_q)
                S_LOADCELL: begin
                    load_pend_q <= 1'b1;
                    state_q     <= S_FETCH;
                end
                S_FETCH: begin
                    // Tape data addressed in LOADCELL arrives here.
                    if (load_pend_q) begin
                        cell_q      <= arrayDataIn;
                        load_pend_q <= 1'b0;
                    end
                    if (enable) state_q <= S_EXEC;
                end
                S_EXEC: begin
                    pc_q    <= pc_next;
                    state_q <= pc_wrap ? S_HALT : S_FETCH;
                    case (codeIn)
                        8'h00: begin
                            pc_q    <= pc_q;
                            state_q <= S_HALT;
                        end
                        OP_RIGHT: begin
                            ptr_q <= ptr_q + 1'b1;
                            if (!pc_wrap) state_q <= S_LOADCELL;
                        end
                        OP_LEFT: begin
                            ptr_q <= ptr_q - 1'b1;
                            if (!pc_wrap) state_q <= S_LOADCELL;
                        end
                        OP_OUT: begin
                            pc_q    <= pc_q;
                            state_q <= S_OUT;
                        end
                        OP_IN: begin
                            pc_q    <= pc_q;
                            state_q <= S_IN;
                        end
                        OP_OPEN: begin
                            if (cell_q != '0) begin
                                if (stack_full) begin
                                    error_q <= 2'b01;
                                    pc_q    <= pc_q;
                                    state_q <= S_HALT;
                                end else begin
                                    sp_q <= sp_q + 1'b1;
                                end
                            end else begin
                                depth_q <= ADDR_CODE'(1);
                                if (pc_wrap) error_q <= 2'b11;
                                else state_q <= S_SKIP;
                            end
                        end
                        OP_CLOSE: begin
                            if (sp_q == '0) begin
                                error_q <= 2'b10;
                                pc_q    <= pc_q;
                                state_q <= S_HALT;
                            end else if (cell_q != '0) begin
                                pc_q    <= top + 1'b1;
                                state_q <= S_FETCH;
                            end else begin
                                sp_q <= sp_q - 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_OUT: begin
                    if (outReady) begin
                        pc_q    <= pc_next;
                        state_q <= pc_wrap ? S_HALT : S_FETCH;
                    end
                end
                S_IN: begin
                    if (inValid) begin
                        pc_q    <= pc_next;
                        state_q <= pc_wrap ? S_HALT : S_FETCH;
                    end
                end
                S_SKIP: begin
                    // Phase 0 presents pc to code RAM, phase 1 inspects the returned byte.
                    skip_ph_q <= !skip_ph_q;
                    if (skip_ph_q) begin
                        pc_q <= pc_next;
                        if (codeIn == 8'h00) begin
                            pc_q    <= pc_q;
                            error_q <= 2'b11;
                            state_q <= S_HALT;
                        end else if (codeIn == OP_CLOSE && depth_q == ADDR_CODE'(1)) begin
                            depth_q <= '0;
                            state_q <= pc_wrap ? S_HALT : S_FETCH;
                        end else begin
                            if (codeIn == OP_OPEN) depth_q <= depth_q + 1'b1;
                            else if (codeIn == OP_CLOSE) depth_q <= depth_q - 1'b1;
                            if (pc_wrap) begin
                                error_q <= 2'b11;
                                state_q <= S_HALT;
                            end
                        end
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end
endmodule

// File: doc/bf_core_v2.md
BF_CORE_V2 -- requirements
Module: bf_core_v2

Interface
REQ-001 SHALL have parameter CELL_W, default 8, width of one tape cell (8..32).
REQ-002 SHALL have parameter ADDR_ARRAY, default 9, tape address width.
REQ-003 SHALL have parameter ADDR_CODE, default 9, code address width.
REQ-004 SHALL have parameter STACK_DEPTH, default 16, number of loop-stack entries (power of 2).
REQ-005 SHALL have port sysClk, in, 1, the only clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-007 SHALL have port enable, in, 1; when low, the core holds in FETCH.
REQ-008 SHALL have ports codeAddr, out, ADDR_CODE, and codeIn, in, 8; code RAM read latency is 1 cycle.
REQ-009 SHALL have ports arrayAddr, out, ADDR_ARRAY; arrayDataOut, out, CELL_W; arrayWe, out, 1; and arrayDataIn, in, CELL_W; tape RAM read latency is 1 cycle and writes are synchronous.
REQ-010 SHALL have ports inValid, in, 1; inData, in, 8; and inReady, out, 1, forming the input byte handshake.
REQ-011 SHALL have ports outValid, out, 1; outData, out, 8; and outReady, in, 1, forming the output byte handshake.
REQ-012 SHALL have ports done, out, 1, asserted when the core has halted, and error, out, 2: 00 none, 01 stack overflow, 10 unmatched ']', 11 unmatched '['.

Function
REQ-013 SHALL implement the states LOADCELL, FETCH, EXEC, OUT, IN, SKIP and HALT.
REQ-014 SHALL hold internal registers pc (ADDR_CODE bits), ptr (ADDR_ARRAY bits), a cell cache (CELL_W bits), a stack sp, and a skip depth counter (ADDR_CODE bits).
REQ-015 SHALL keep the cell cache equal to tape[ptr] at all times by writing through to the tape RAM.
REQ-016 SHALL, in LOADCELL, drive arrayAddr=ptr; the next cycle it captures arrayDataIn into the cell cache and enters FETCH.
REQ-017 SHALL, in FETCH with enable=1, drive codeAddr=pc and enter EXEC; codeIn is valid in EXEC.
REQ-018 SHALL, on '+' or '-', add or subtract 1 from the cell modulo 2^CELL_W, pulse arrayWe for one cycle with the new value, increment pc, and enter FETCH, taking 2 cycles in total.
REQ-019 SHALL, on '>' or '<', add or subtract 1 from ptr modulo 2^ADDR_ARRAY, increment pc, and enter LOADCELL, taking 3 cycles in total.
REQ-020 SHALL, on '.', enter OUT, drive outValid=1 with outData=cell[7:0] held stable, and on outValid&outReady increment pc and enter FETCH.
REQ-021 SHALL, on ',', enter IN with inReady=1; on inValid&inReady it loads the cell with zero-extended inData, pulses arrayWe, increments pc, and enters FETCH.
REQ-022 SHALL, on '[' with cell!=0, push pc, increment pc, and enter FETCH; a push with sp==STACK_DEPTH sets error=01 and enters HALT.
REQ-023 SHALL, on '[' with cell==0, set depth=1, increment pc, and enter SKIP.
REQ-024 SHALL, in SKIP, fetch the code bytes in sequence at 2 cycles per byte: '[' increments depth, ']' decrements depth, and when depth reaches 0 it sets pc to that address+1 and enters FETCH.
REQ-025 SHALL, on ']' with sp==0, set error=10 and enter HALT.
REQ-026 SHALL, on ']' with cell!=0, set pc to top+1 without popping; with cell==0 it pops and increments pc.
REQ-027 SHALL treat byte 0x00 in EXEC, or pc incrementing past 2^ADDR_CODE-1, as end of program and enter HALT with error unchanged.
REQ-028 SHALL, if SKIP reaches 0x00 or the end of code with depth>0, set error=11 and enter HALT.
REQ-029 SHALL, for any other byte, increment pc only.
REQ-030 SHALL, in HALT, hold done=1 and all handshake and write strobes at 0 until reset.
REQ-031 SHALL assert arrayWe only in EXEC or IN, never in two consecutive cycles.
REQ-032 SHALL let a deasserted enable affect only FETCH; an in-flight OUT or IN waits on its handshake regardless of enable.

Reset
REQ-033 SHALL, while reset=1, clear pc, ptr, sp, depth, cell, done, error, arrayWe, inReady and outValid to 0.
REQ-034 SHALL, on the first cycle after reset falls, enter LOADCELL.
REQ-035 SHALL, on a reset asserted mid-operation (including during OUT with outReady low or during SKIP), abort the operation in the same cycle with no further tape write.
REQ-036 SHALL NOT clear the tape RAM on reset.

Verification
REQ-037 SHALL be covered by a directed test: program "+++." with outReady=1 -> one outValid pulse, outData=0x03, then done=1 at pc=4, error=00.
REQ-038 SHALL be covered by a directed test: CELL_W=16, program "-." -> tape[0]=0xFFFF, outData=0xFF.
REQ-039 SHALL be covered by a directed test: program "<+" -> ptr=2^ADDR_ARRAY-1 and that cell=1.
REQ-040 SHALL be covered by a directed test: program "++[->+<]>." -> outData=0x02, with the stack empty at halt.
REQ-041 SHALL be covered by a directed test: program "[[+]]." with tape zero -> skip lands at pc=5, outData=0x00; program "]" -> error=10; with STACK_DEPTH=2, program "+[[[" -> error=01.
REQ-042 SHALL be covered by a directed test: program ",." with inValid delayed 5 cycles and outReady held low 3 cycles -> stall without tape write, echoing the input byte exactly once.
